ctrl_pipe: RTL and testbench

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/lc3b_types.sv | 27 ++
 rtl/ctrl_hazard_unit.sv | 24 ++
 rtl/ctrl_pipe.sv | 134 +++++++++++++
 tb/tb_ctrl_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types for the control-word pipe.
//   lc3b_reg      : 3-bit architectural register index (R0..R7)
//   lc3b_control  : decoded control word carried down the pipe
//   CTRL_NOP      : the default control word produced by gen_control
//   *_DEF         : default geometry of ctrl_pipe
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] aluop;
        logic       regFile_load;
        logic       cc_load;
        logic       mem2_read;
        logic       mem2_write;
        logic       br_en;
    } lc3b_control;

    // gen_control's default word: opcode BR with nothing enabled.
    localparam lc3b_control CTRL_NOP = '0;

    localparam int STAGES_DEF      = 3;
    localparam int LOAD_LAT_DEF    = 1;
    localparam int FLUSH_DEPTH_DEF = 2;

endpackage

// File: rtl/ctrl_hazard_unit.sv
// Load-use comparator for one pipe stage.
//   stg_valid/stg_is_load/stg_wr/stg_dest : state of the stage being checked
//   src1/src1_used/src2/src2_used         : sources of the ID instruction
//   hit                                   : ID reads a not-yet-forwardable load result
module ctrl_hazard_unit
    import lc3b_types::*;
(
    input  logic    stg_valid,
    input  logic    stg_is_load,
    input  logic    stg_wr,
    input  lc3b_reg stg_dest,
    input  lc3b_reg src1,
    input  logic    src1_used,
    input  lc3b_reg src2,
    input  logic    src2_used,
    output logic    hit
);

    // R7 (JSR/TRAP link) is compared like any other register.
    assign hit = stg_valid && stg_is_load && stg_wr &&
                 ((src1_used && (src1 == stg_dest)) ||
                  (src2_used && (src2 == stg_dest)));

endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline with load-use interlock and flush.
//   clk, reset_n        : clock (rising) and async active-low reset
//   id_*                : decoded instruction presented by ID
//   mem_stall           : freeze every stage
//   flush               : kill the youngest FLUSH_DEPTH stages and the ID entry
//   stg_valid/ctrl/dest : per-stage state, stage 0 = EX
//   hazard_stall        : hold PC and IF/ID this cycle
//   bubble_cnt          : saturating count of hazard bubbles
module ctrl_pipe
    import lc3b_types::*;
#(
    parameter int STAGES      = STAGES_DEF,
    parameter int LOAD_LAT    = LOAD_LAT_DEF,
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      id_valid,
    input  lc3b_control               id_ctrl,
    input  lc3b_reg                   id_dest,
    input  logic                      id_is_load,
    input  lc3b_reg                   id_src1,
    input  lc3b_reg                   id_src2,
    input  logic                      id_src1_used,
    input  logic                      id_src2_used,
    input  logic                      mem_stall,
    input  logic                      flush,
    output logic [STAGES-1:0]         stg_valid,
    output lc3b_control [STAGES-1:0]  stg_ctrl,
    output lc3b_reg [STAGES-1:0]      stg_dest,
    output logic                      hazard_stall,
    output logic [15:0]               bubble_cnt
);

    generate
        if (!(LOAD_LAT >= 1 && LOAD_LAT < STAGES &&
              FLUSH_DEPTH >= 1 && FLUSH_DEPTH <= STAGES)) begin : g_bad_params
            $error("ctrl_pipe: need 1 <= LOAD_LAT < STAGES and 1 <= FLUSH_DEPTH <= STAGES");
        end
    endgenerate

    logic [STAGES-1:0]        vld_q, vld_d;
    logic [STAGES-1:0]        load_q, load_d;
    lc3b_control [STAGES-1:0] ctrl_q, ctrl_d;
    lc3b_reg [STAGES-1:0]     dest_q, dest_d;
    logic [15:0]              cnt_q;
    logic [LOAD_LAT-1:0]      hit;

    // Only the youngest LOAD_LAT stages can hold an unforwardable load.
    generate
        for (genvar k = 0; k < LOAD_LAT; k++) begin : g_hz
            ctrl_hazard_unit u_hz (
                .stg_valid   (vld_q[k]),
                .stg_is_load (load_q[k]),
                .stg_wr      (ctrl_q[k].regFile_load),
                .stg_dest    (dest_q[k]),
                .src1        (id_src1),
                .src1_used   (id_src1_used),
                .src2        (id_src2),
                .src2_used   (id_src2_used),
                .hit         (hit[k])
            );
        end
    endgenerate

    // Evaluated even under mem_stall; a flush already removes the ID entry.
    assign hazard_stall = id_valid && !flush && (|hit);

    // Next state. Priority: mem_stall, flush, hazard, advance. Flush and
    // hazard both shift by one; they differ only in how many young stages
    // are replaced by bubbles.
    always_comb begin
        vld_d  = vld_q;
        load_d = load_q;
        ctrl_d = ctrl_q;
        dest_d = dest_q;
        if (!mem_stall) begin
            for (int k = 1; k < STAGES; k++) begin
                vld_d[k]  = vld_q[k-1];
                load_d[k] = load_q[k-1];
                ctrl_d[k] = ctrl_q[k-1];
                dest_d[k] = dest_q[k-1];
            end
            if (flush || hazard_stall || !id_valid) begin
                vld_d[0]  = 1'b0;
                load_d[0] = 1'b0;
                ctrl_d[0] = CTRL_NOP;
                dest_d[0] = '0;
            end else begin
                vld_d[0]  = 1'b1;
                load_d[0] = id_is_load;
                ctrl_d[0] = id_ctrl;
                dest_d[0] = id_dest;
            end
            if (flush) begin
                for (int k = 0; k < FLUSH_DEPTH; k++) begin
                    vld_d[k]  = 1'b0;
                    load_d[k] = 1'b0;
                    ctrl_d[k] = CTRL_NOP;
                    dest_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            load_q <= '0;
            dest_q <= '0;
            cnt_q  <= '0;
            for (int k = 0; k < STAGES; k++) ctrl_q[k] <= CTRL_NOP;
        end else begin
            vld_q  <= vld_d;
            load_q <= load_d;
            ctrl_q <= ctrl_d;
            dest_q <= dest_d;
            if (!mem_stall && hazard_stall && (cnt_q != 16'hFFFF))
                cnt_q <= cnt_q + 16'd1;
        end
    end

    // Invalid stages always present a NOP, whatever the register holds.
    always_comb begin
        stg_ctrl = '0;
        for (int k = 0; k < STAGES; k++)
            stg_ctrl[k] = vld_q[k] ? ctrl_q[k] : CTRL_NOP;
    end

    assign stg_valid  = vld_q;
    assign stg_dest   = dest_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboarded bench for ctrl_pipe: a queue-based reference pipe predicts
// each cycle's outputs, a negedge monitor compares. A second deep instance
// exercises bubble_cnt saturation with a closed-form expectation.
module tb_ctrl_pipe;
    import lc3b_types::*;

    localparam int S  = 3;
    localparam int LL = 1;
    localparam int FD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 id_valid, id_is_load, id_src1_used, id_src2_used;
    lc3b_control          id_ctrl;
    lc3b_reg              id_dest, id_src1, id_src2;
    logic                 mem_stall, flush;
    logic [S-1:0]         stg_valid;
    lc3b_control [S-1:0]  stg_ctrl;
    lc3b_reg [S-1:0]      stg_dest;
    logic                 hazard_stall;
    logic [15:0]          bubble_cnt;

    ctrl_pipe #(.STAGES(S), .LOAD_LAT(LL), .FLUSH_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_ctrl(id_ctrl), .id_dest(id_dest), .id_is_load(id_is_load),
        .id_src1(id_src1), .id_src2(id_src2), .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .mem_stall(mem_stall), .flush(flush),
        .stg_valid(stg_valid), .stg_ctrl(stg_ctrl), .stg_dest(stg_dest),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    // Deep instance: a stream of loads each depending on the previous one.
    localparam int SS = 9;
    localparam int SL = 8;
    logic                 sat_rst_n;
    lc3b_control          sat_ctrl_in;
    logic [SS-1:0]        sat_valid;
    lc3b_control [SS-1:0] sat_ctrl;
    lc3b_reg [SS-1:0]     sat_dest;
    logic                 sat_hz;
    logic [15:0]          sat_cnt;
    bit                   sat_done = 1'b0;

    ctrl_pipe #(.STAGES(SS), .LOAD_LAT(SL), .FLUSH_DEPTH(1)) u_sat (
        .clk(clk), .reset_n(sat_rst_n),
        .id_valid(1'b1), .id_ctrl(sat_ctrl_in), .id_dest(3'd1), .id_is_load(1'b1),
        .id_src1(3'd1), .id_src2(3'd0), .id_src1_used(1'b1), .id_src2_used(1'b0),
        .mem_stall(1'b0), .flush(1'b0),
        .stg_valid(sat_valid), .stg_ctrl(sat_ctrl), .stg_dest(sat_dest),
        .hazard_stall(sat_hz), .bubble_cnt(sat_cnt)
    );

    typedef struct packed {
        logic        v;
        lc3b_control c;
        lc3b_reg     d;
        logic        ld;
    } ent_t;

    typedef struct packed {
        logic [S-1:0]        v;
        lc3b_control [S-1:0] c;
        lc3b_reg [S-1:0]     d;
        logic                hz;
        logic [15:0]         cnt;
    } exp_t;

    ent_t m[$];      // reference pipe, index 0 = EX
    int   mcnt;      // reference bubble count
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    function automatic lc3b_control mk(input int op, input bit wr, input bit rd);
        lc3b_control c;
        c = CTRL_NOP;
        c.opcode       = 4'(op);
        c.regFile_load = wr;
        c.cc_load      = wr;
        c.mem2_read    = rd;
        return c;
    endfunction

    function automatic ent_t bub();
        ent_t b;
        b   = '0;
        b.c = CTRL_NOP;
        return b;
    endfunction

    function automatic bit model_hz();
        bit h = 1'b0;
        for (int k = 0; k < LL; k++)
            if (m[k].v && m[k].ld && m[k].c.regFile_load &&
                ((id_src1_used && id_src1 == m[k].d) || (id_src2_used && id_src2 == m[k].d)))
                h = 1'b1;
        return h && id_valid && !flush;
    endfunction

    task automatic model_reset();
        m.delete();
        for (int k = 0; k < S; k++) m.push_back(bub());
        mcnt = 0;
    endtask

    task automatic model_step();
        ent_t e;
        if (mem_stall) return;
        if (flush) begin
            m.push_front(bub());
            void'(m.pop_back());
            for (int k = 0; k < FD; k++) m[k] = bub();
        end else if (model_hz()) begin
            m.push_front(bub());
            void'(m.pop_back());
            if (mcnt < 65535) mcnt++;
        end else begin
            if (id_valid) begin
                e.v = 1'b1; e.c = id_ctrl; e.d = id_dest; e.ld = id_is_load;
            end else e = bub();
            m.push_front(e);
            void'(m.pop_back());
        end
    endtask

    // Called #1 after a rising edge with the new inputs applied: predict
    // what the monitor sees before the next edge, then advance the model.
    task automatic cyc();
        exp_t e;
        for (int k = 0; k < S; k++) begin
            e.v[k] = m[k].v;
            e.c[k] = m[k].v ? m[k].c : CTRL_NOP;
            e.d[k] = m[k].d;
        end
        e.hz  = model_hz();
        e.cnt = 16'(mcnt);
        sb.push_back(e);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_id(input bit v, input lc3b_control c, input int d, input bit ld,
                          input int s1, input bit u1, input int s2, input bit u2);
        id_valid = v; id_ctrl = c; id_dest = 3'(d); id_is_load = ld;
        id_src1 = 3'(s1); id_src1_used = u1; id_src2 = 3'(s2); id_src2_used = u2;
    endtask

    task automatic idle(input int n);
        set_id(0, CTRL_NOP, 0, 0, 0, 0, 0, 0);
        repeat (n) cyc();
    endtask

    function automatic int rreg();
        int r = int'($urandom_range(0, 4));
        return (r == 4) ? 7 : r;
    endfunction

    task automatic rand_id();
        bit ld = ($urandom_range(0, 2) == 0);
        set_id($urandom_range(0, 9) != 0,
               mk(ld ? 6 : int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, ld),
               rreg(), ld, rreg(), $urandom_range(0, 3) != 0, rreg(), $urandom_range(0, 1) != 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stg_valid",    64'(stg_valid),    64'(e.v));
            chk("stg_ctrl",     64'(stg_ctrl),     64'(e.c));
            chk("stg_dest",     64'(stg_dest),     64'(e.d));
            chk("hazard_stall", 64'(hazard_stall), 64'(e.hz));
            chk("bubble_cnt",   64'(bubble_cnt),   64'(e.cnt));
        end
    end

    // Saturation: after the first edge, edge e is an advance when
    // (e-1)%9==0 and a hazard otherwise, so E edges give E-ceil(E/9) bubbles.
    function automatic int sat_exp(input int E);
        int n = E - (E + 8) / 9;
        return (n > 65535) ? 65535 : n;
    endfunction

    initial begin
        sat_ctrl_in = mk(6, 1'b1, 1'b1);
        sat_rst_n = 1'b0;
        @(negedge clk);
        sat_rst_n = 1'b1;
        repeat (9000) @(posedge clk);
        #1;
        chk("sat_cnt_mid", 64'(sat_cnt), 64'(sat_exp(9000)));
        chk("sat_hz_adv",  64'(sat_hz),  64'(0));
        @(posedge clk);
        #1;
        chk("sat_hz_load", 64'(sat_hz), 64'(1));
        repeat (65000) @(posedge clk);
        #1;
        chk("sat_cnt_full", 64'(sat_cnt), 64'(sat_exp(74001)));
        sat_done = 1'b1;
    end

    initial begin
        bit ms_prev, hz_prev;
        lc3b_control [S-1:0] nopv;
        lc3b_control add_c, ldr_c;
        for (int k = 0; k < S; k++) nopv[k] = CTRL_NOP;
        add_c = mk(1, 1'b1, 1'b0);
        ldr_c = mk(6, 1'b1, 1'b1);

        reset_n = 1'b0; mem_stall = 1'b0; flush = 1'b0;
        set_id(1, ldr_c, 1, 1, 1, 1, 1, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  64'(stg_valid),    64'(0));
        chk("rst_ctrl",   64'(stg_ctrl),     64'(nopv));
        chk("rst_hazard", 64'(hazard_stall), 64'(0));
        chk("rst_cnt",    64'(bubble_cnt),   64'(0));
        #2 reset_n = 1'b1;

        // ADD R1 flows through all stages
        set_id(1, add_c, 1, 0, 2, 1, 3, 1);
        cyc();
        idle(3);

        // LDR R2 ; ADD R3,R2,R4 -> one bubble
        set_id(1, ldr_c, 2, 1, 0, 1, 0, 0);
        cyc();
        set_id(1, add_c, 3, 0, 2, 1, 4, 1);
        cyc();
        cyc();
        idle(3);
        chk("load_use_bubbles", 64'(bubble_cnt), 64'(1));

        // LDR R2 ; ADD R3,R5,#imm -> no stall
        set_id(1, ldr_c, 2, 1, 0, 1, 0, 0);
        cyc();
        set_id(1, add_c, 3, 0, 5, 1, 2, 0);
        cyc();
        idle(3);

        // Full pipe frozen by mem_stall for 3 cycles
        for (int i = 1; i <= 3; i++) begin
            set_id(1, add_c, i, 0, 0, 0, 0, 0);
            cyc();
        end
        set_id(1, add_c, 7, 0, 0, 0, 0, 0);
        mem_stall = 1'b1;
        repeat (3) cyc();
        mem_stall = 1'b0;
        idle(1);

        // Flush of a full pipe, then flush held under mem_stall
        for (int i = 4; i <= 6; i++) begin
            set_id(1, add_c, i, 0, 0, 0, 0, 0);
            cyc();
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_id(1, add_c, i + 3, 0, 0, 0, 0, 0);
            cyc();
        end
        flush = 1'b1; mem_stall = 1'b1;
        repeat (2) cyc();
        mem_stall = 1'b0;
        cyc();
        flush = 1'b0;
        idle(1);

        // Random traffic; ID held across hazards and mem_stall, flush held under mem_stall
        hz_prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            ms_prev = mem_stall;
            if (!(ms_prev || hz_prev)) rand_id();
            if (!(ms_prev && flush)) flush = ($urandom_range(0, 9) == 0);
            mem_stall = ($urandom_range(0, 6) == 0);
            hz_prev = model_hz() && !mem_stall;
            cyc();
        end

        // Asynchronous reset in mid-cycle with work in flight
        set_id(1, add_c, 1, 0, 0, 0, 0, 0);
        mem_stall = 1'b0; flush = 1'b0;
        cyc(); cyc();
        set_id(1, ldr_c, 2, 1, 0, 0, 0, 0);
        cyc();
        set_id(1, add_c, 3, 0, 2, 1, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("async_valid",  64'(stg_valid),    64'(0));
        chk("async_ctrl",   64'(stg_ctrl),     64'(nopv));
        chk("async_dest",   64'(stg_dest),     64'(0));
        chk("async_hazard", 64'(hazard_stall), 64'(0));
        chk("async_cnt",    64'(bubble_cnt),   64'(0));
        model_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;
        set_id(1, add_c, 4, 0, 0, 0, 0, 0);
        cyc();
        idle(3);

        for (int i = 0; i < 100000 && !sat_done; i++) @(posedge clk);
        if (!sat_done) begin
            checks++;
            errors++;
            $display("FAIL sat_timeout actual=0 required=1");
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
